nrs_interp_engine: RTL and testbench

Sequential, parametrised linear-interpolation engine for NRS-based channel estimation in the NB-IoT receiver. It accepts one pair of complex pilot estimates (Ea, Eb) `STEP` subcarriers apart and streams `STEP` interpolated, held or extrapolated complex estimates, one per cycle. A valid/ready handshake on both sides supports back-pressure. It sits between the pilot LS-estimator and the equaliser's channel buffer.

---
 rtl/nrs_interp_pkg.sv | 28 ++
 rtl/interp_lane.sv | 86 ++++++++
 rtl/nrs_interp_engine.sv | 130 +++++++++++++
 tb/tb_nrs_interp_engine.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrs_interp_pkg.sv
// nrs_interp_pkg: shared encodings and constants for the NRS interpolation engine.
// Holds the mode encodings, the FSM state type and the constant-divide helpers
// (Q shift and reciprocal of STEP) used by the lane scaler.
package nrs_interp_pkg;

  // Burst modes; encoding 3 is not listed and behaves as hold.
  localparam logic [1:0] MODE_INTERP = 2'd0;
  localparam logic [1:0] MODE_HOLD   = 2'd1;
  localparam logic [1:0] MODE_EXTRAP = 2'd2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Fraction bits of the fixed-point reciprocal.
  function automatic int nrs_q(input int w);
    return w + 6;
  endfunction

  // round(2^Q / step), computed as floor((2^(Q+1)/step + 1) / 2).
  function automatic longint nrs_recip(input int w, input int step);
    longint num;
    num = longint'(1) << (nrs_q(w) + 1);
    return (num / step + 1) / 2;
  endfunction

endpackage

// File: rtl/interp_lane.sv
// interp_lane: one component (I or Q) of the interpolator.
// Ports: load/mode/ea/eb start a burst (latch d, seed acc); advance emits
// scale(acc) into the sample register and steps acc by d; sample is the registered result.
module interp_lane
  import nrs_interp_pkg::*;
#(
  parameter int W     = 17,
  parameter int STEP  = 6,
  parameter int OUT_W = W + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [1:0]              mode,
  input  logic                    advance,
  input  logic signed [W-1:0]     ea,
  input  logic signed [W-1:0]     eb,
  output logic signed [OUT_W-1:0] sample
);

  localparam int     ACC_W  = W + $clog2(2 * STEP) + 2;
  localparam int     D_W    = W + 1;
  localparam int     Q      = nrs_q(W);
  localparam longint RECIP  = nrs_recip(W, STEP);
  localparam int     PROD_W = ACC_W + Q + 1;

  localparam logic signed [ACC_W-1:0]  STEP_A  = ACC_W'(STEP);
  localparam logic signed [PROD_W-1:0] RECIP_P = PROD_W'(RECIP);
  localparam logic signed [PROD_W-1:0] RND_P   = PROD_W'(longint'(1) << (Q - 1));

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [D_W-1:0]    d_q, d_d;
  logic signed [OUT_W-1:0]  sample_q, sample_d;

  logic signed [ACC_W-1:0]  ea_x, eb_x, seed_x, acc_init, d_x;
  logic signed [D_W-1:0]    diff;
  logic signed [PROD_W-1:0] acc_p, prod, shifted;
  logic                     slope_on;
  logic                     unused_hi_bits;

  assign ea_x     = ACC_W'(ea);
  assign eb_x     = ACC_W'(eb);
  assign seed_x   = (mode == MODE_EXTRAP) ? eb_x : ea_x;
  assign acc_init = seed_x * STEP_A;
  assign diff     = D_W'(eb) - D_W'(ea);
  // Only interpolate/extrapolate carry a slope; hold and the spare code do not.
  assign slope_on = (mode == MODE_INTERP) || (mode == MODE_EXTRAP);
  assign d_x      = ACC_W'(d_q);

  // Divide by STEP as multiply by the rounded reciprocal, then round half up.
  assign acc_p   = PROD_W'(acc_q);
  assign prod    = acc_p * RECIP_P + RND_P;
  assign shifted = prod >>> Q;
  assign unused_hi_bits = ^shifted[PROD_W-1:OUT_W];

  always_comb begin
    acc_d    = acc_q;
    d_d      = d_q;
    sample_d = sample_q;
    if (advance) begin
      sample_d = shifted[OUT_W-1:0];
      acc_d    = acc_q + d_x;
    end
    // A reload may coincide with the last issue of the previous burst; the
    // sample still comes from the old acc, the new burst overwrites acc/d.
    if (load) begin
      acc_d = acc_init;
      d_d   = slope_on ? diff : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      d_q      <= '0;
      sample_q <= '0;
    end else begin
      acc_q    <= acc_d;
      d_q      <= d_d;
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;

endmodule

// File: rtl/nrs_interp_engine.sv
// nrs_interp_engine: streams STEP interpolated/held/extrapolated estimates per pilot pair.
// Ports: in_valid/in_ready + ea/eb/mode accept a pair; out_valid/out_ready + out_i/out_q/
// out_idx/out_last deliver one sample per cycle; stalled outputs freeze acc, k and data.
module nrs_interp_engine
  import nrs_interp_pkg::*;
#(
  parameter int W     = 17,
  parameter int STEP  = 6,
  parameter int OUT_W = W + 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [W-1:0]        ea_i,
  input  logic signed [W-1:0]        ea_q,
  input  logic signed [W-1:0]        eb_i,
  input  logic signed [W-1:0]        eb_q,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_i,
  output logic signed [OUT_W-1:0]    out_q,
  output logic [$clog2(STEP)-1:0]    out_idx,
  output logic                       out_last
);

  localparam int            KW     = $clog2(STEP);
  localparam logic [KW-1:0] K_LAST = KW'(STEP - 1);

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   out_idx_q, out_idx_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;

  logic            issue, k_is_last, in_ready_c, accept, advance;

  // issue: the output register is free or being consumed this cycle.
  assign issue      = ~out_valid_q | out_ready;
  assign k_is_last  = (k_q == K_LAST);
  assign in_ready_c = (state_q == ST_IDLE) || (state_q == ST_DRAIN) ||
                      ((state_q == ST_RUN) && k_is_last && issue);
  assign accept     = in_valid & in_ready_c;
  assign advance    = (state_q == ST_RUN) & issue;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_RUN: begin
        if (issue) begin
          out_valid_d = 1'b1;
          out_idx_d   = k_q;
          out_last_d  = k_is_last;
          if (k_is_last) begin
            k_d     = '0;
            state_d = accept ? ST_RUN : ST_DRAIN;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) out_valid_d = 1'b0;
        if (accept) begin
          state_d = ST_RUN;
          k_d     = '0;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        // IDLE, and recovery from the unused encoding.
        state_d = ST_IDLE;
        if (accept) begin
          state_d = ST_RUN;
          k_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  interp_lane #(.W(W), .STEP(STEP), .OUT_W(OUT_W)) u_lane_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .mode    (mode),
    .advance (advance),
    .ea      (ea_i),
    .eb      (eb_i),
    .sample  (out_i)
  );

  interp_lane #(.W(W), .STEP(STEP), .OUT_W(OUT_W)) u_lane_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .mode    (mode),
    .advance (advance),
    .ea      (ea_q),
    .eb      (eb_q),
    .sample  (out_q)
  );

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_nrs_interp_engine.sv
// tb_nrs_interp_engine: scoreboard bench for nrs_interp_engine.
// Driver pushes the expected burst when a pair is accepted; monitor pops and
// compares each consumed sample, and checks stalled outputs stay frozen.
module tb_nrs_interp_engine;

  localparam int W     = 17;
  localparam int STEP  = 6;
  localparam int OUT_W = W + 2;
  localparam int KW    = $clog2(STEP);
  localparam int Q     = W + 6;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [W-1:0]     ea_i = '0, ea_q = '0, eb_i = '0, eb_q = '0;
  logic [1:0]              mode = 2'd0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [OUT_W-1:0] out_i, out_q;
  logic [KW-1:0]           out_idx;
  logic                    out_last;

  nrs_interp_engine #(.W(W), .STEP(STEP), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ea_i      (ea_i),
    .ea_q      (ea_q),
    .eb_i      (eb_i),
    .eb_q      (eb_q),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint i;
    longint q;
    longint idx;
    longint last;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     rdy_mode = 0;    // 0: always ready, 1: random, 2: stall window
  int     stall_lo = 0, stall_hi = -1;
  int     run_len = 0, max_run = 0;
  longint last_obs_i = 0;
  longint recip;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: acc_k = STEP*seed + k*slope, then the defined reciprocal scaler.
  function automatic longint exp_val(input longint a, input longint b, input int m, input int k);
    longint seed, slope, acc;
    seed  = (m == 2) ? b : a;
    slope = (m == 0 || m == 2) ? (b - a) : 0;
    acc   = STEP * seed + k * slope;
    return (acc * recip + (longint'(1) << (Q - 1))) >>> Q;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge,
  // leaving in_valid high so a following call runs back-to-back.
  task automatic send_pair(input int a_i, input int a_q, input int b_i, input int b_q,
                           input int m, output int ov, output int idx);
    bit   done;
    exp_t e;
    done = 0; ov = 0; idx = 0;
    ea_i = a_i[W-1:0]; ea_q = a_q[W-1:0];
    eb_i = b_i[W-1:0]; eb_q = b_q[W-1:0];
    mode = m[1:0];
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      #2;
      if (in_ready) begin
        done = 1;
        ov   = int'(out_valid);
        idx  = int'(out_idx);
        for (int k = 0; k < STEP; k++) begin
          e.i    = exp_val(a_i, b_i, m, k);
          e.q    = exp_val(a_q, b_q, m, k);
          e.idx  = k;
          e.last = (k == STEP - 1) ? 1 : 0;
          sb.push_back(e);
        end
      end
      @(negedge clk);
    end
    if (!done) begin
      check_val("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    in_valid = 1'b0;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_val("drain", longint'(sb.size()) + longint'(out_valid), 0);
    @(negedge clk);
  endtask

  // Monitor: choose out_ready at each negedge, then score the sample that
  // the next rising edge will consume.
  bit                      prev_stall = 0;
  logic signed [OUT_W-1:0] prev_i, prev_q;
  logic [KW-1:0]           prev_idx;
  always begin
    exp_t e;
    @(negedge clk);
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      default: out_ready = 1'b1;
    endcase
    #1;
    if (!rst_n) begin
      prev_stall = 0;
      run_len    = 0;
    end else begin
      if (prev_stall) begin
        check_val("hold_i", longint'(out_i), longint'(prev_i));
        check_val("hold_q", longint'(out_q), longint'(prev_q));
        check_val("hold_idx", longint'(out_idx), longint'(prev_idx));
      end
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_val("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check_val("out_i", longint'(out_i), e.i);
          check_val("out_q", longint'(out_q), e.q);
          check_val("out_idx", longint'(out_idx), e.idx);
          check_val("out_last", longint'(out_last), e.last);
          if (e.last == 1) last_obs_i = longint'(out_i);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_i     = out_i;
      prev_q     = out_q;
      prev_idx   = out_idx;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ov, idx, ov2, idx2, t;
    bit hit;
    recip = ((longint'(1) << (Q + 1)) / STEP + 1) / 2;

    // Reset state.
    rst_n = 1'b0;
    #13;
    check_val("rst_out_valid", longint'(out_valid), 0);
    check_val("rst_in_ready", longint'(in_ready), 1);
    check_val("rst_out_i", longint'(out_i), 0);
    check_val("rst_out_idx", longint'(out_idx), 0);
    check_val("rst_out_last", longint'(out_last), 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // Interpolate, with first-sample latency.
    send_pair(60, -120, 120, 0, 0, ov, idx);
    in_valid = 1'b0;
    check_val("lat_edge_t", longint'(out_valid), 0);
    @(negedge clk);
    #1;
    check_val("lat_edge_t1", longint'(out_valid), 1);
    check_val("lat_idx0", longint'(out_idx), 0);
    wait_drain();

    // Extrapolate, hold, and the spare code.
    send_pair(60, -120, 120, 0, 2, ov, idx);
    wait_drain();
    send_pair(60, -120, 120, 0, 1, ov, idx);
    wait_drain();
    send_pair(60, -120, 120, 0, 3, ov, idx);
    wait_drain();

    // Output stalled for a few cycles, second pair queued behind it.
    rdy_mode = 2;
    send_pair(60, -120, 120, 0, 0, ov, idx);
    stall_lo = cyc + 2;
    stall_hi = cyc + 4;
    send_pair(-300, 500, 900, -700, 0, ov2, idx2);
    check_val("bp_accept_valid", ov2, 1);
    check_val("bp_accept_idx", idx2, STEP - 2);
    wait_drain();
    rdy_mode = 0;

    // Back-to-back bursts with no bubble.
    max_run = 0;
    send_pair(60, -120, 120, 0, 0, ov, idx);
    send_pair(1000, -2000, -1000, 4000, 2, ov2, idx2);
    check_val("b2b_accept_idx", idx2, STEP - 2);
    wait_drain();
    check_val("b2b_run_len", max_run, 2 * STEP);

    // Full-scale extrapolation.
    send_pair(-65536, 65535, 65535, -65536, 2, ov, idx);
    wait_drain();
    check_val("extreme_k5_i", last_obs_i, 174761);

    // Reset in the middle of a burst.
    send_pair(60, -120, 120, 0, 0, ov, idx);
    in_valid = 1'b0;
    hit = 0;
    t = 0;
    while (!hit && t < 40) begin
      @(negedge clk);
      #2;
      if (out_valid && out_idx == KW'(3)) hit = 1;
      t++;
    end
    check_val("rst_reach_k3", hit, 1);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", longint'(out_valid), 0);
    check_val("mid_rst_i", longint'(out_i), 0);
    check_val("mid_rst_idx", longint'(out_idx), 0);
    sb.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    check_val("post_rst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    send_pair(60, -120, 120, 0, 0, ov, idx);
    wait_drain();

    // Random pairs and modes under random back-pressure.
    rdy_mode = 1;
    for (int n = 0; n < 10; n++) begin
      send_pair(int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
                int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
                int'($urandom_range(0, 3)), ov, idx);
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
      end
    end
    wait_drain();
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
